counter_sched: RTL and testbench
================================

COUNTER_SCHED -- requirements
Module: counter_sched

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning the number of requesters sharing the counter.
REQ-002 SHALL have parameter CW, default 3, meaning the counter width in bits.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning reset, asynchronous and active-high.
REQ-005 SHALL have port req  input  N_REQ  meaning level requests, where bit i is requester i.
REQ-006 SHALL have port len  input  CW  meaning the slot length code, sampled only at grant.
REQ-007 SHALL have port gnt  output  N_REQ  meaning the one-hot grant, held for the whole slot.
REQ-008 SHALL have port count  output  CW  meaning the shared counter value during the slot.
REQ-009 SHALL have port done  output  N_REQ  meaning a one-cycle pulse to the requester whose slot completed.
REQ-010 SHALL have port abort  output  1  meaning a one-cycle pulse when a slot ends early.
REQ-011 SHALL have port busy  output  1  meaning the FSM is not in IDLE.

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, RUN and DONE, all outputs registered.
REQ-013 IDLE: when req is nonzero at an edge, the block SHALL move to RUN on that edge, set gnt to onehot(winner), clear count to 0 and latch term = len.
REQ-014 Winner selection SHALL be round-robin: the first set req bit searching upward from rr_ptr, wrapping from N_REQ-1 to 0.
REQ-015 RUN, count != term, req[winner] = 1: the block SHALL increment count by 1 per cycle and hold gnt.
REQ-016 RUN, count == term, req[winner] = 1: the block SHALL go to DONE, clear gnt, set done = onehot(winner) and set rr_ptr = (winner+1) mod N_REQ.
REQ-017 A slot SHALL last term+1 RUN cycles (len=0 gives 1 cycle; len=2^CW-1 gives 2^CW cycles); count SHALL never wrap within a slot.
REQ-018 RUN, req[winner] = 0 (including on the terminal cycle): the block SHALL go directly to IDLE, clear gnt, clear count, pulse abort for 1 cycle, keep done at 0 and set rr_ptr = (winner+1) mod N_REQ.
REQ-019 DONE: the block SHALL return to IDLE after exactly 1 cycle, clear done and clear count; no arbitration SHALL occur in DONE.
REQ-020 Request-to-grant latency from IDLE SHALL be 1 edge; the minimum back-to-back gap SHALL be 1 cycle (DONE) plus 1 cycle (IDLE).
REQ-021 Changes to len during RUN SHALL have no effect; requests from non-winners during RUN SHALL be ignored until the next IDLE arbitration.
REQ-022 gnt SHALL be at most one-hot at all times, and gnt and done SHALL never both be nonzero.
REQ-023 busy SHALL be 1 in RUN and DONE and 0 in IDLE.

Reset
REQ-024 While rst = 1, the block SHALL immediately and asynchronously force state = IDLE, gnt = 0, count = 0, done = 0, abort = 0, busy = 0 and rr_ptr = 0.
REQ-025 Reset asserted mid-RUN SHALL drop the grant without a done or abort pulse; after release, arbitration SHALL restart with priority from requester 0.

Verification
REQ-026 Single request: req=0001, len=3 -> gnt=0001 for 4 cycles with count 0,1,2,3; then done=0001 for 1 cycle; then busy=0.
REQ-027 Round-robin: req=1111 held, len=0 -> grants in order 0001, 0010, 0100, 1000, 0001, each for 1 cycle, each followed by a done pulse.
REQ-028 Full length: len=7, CW=3 -> count runs 0..7 over 8 cycles with no wrap to 0 before DONE.
REQ-029 Abort: req=0100 granted with len=5; drop req[2] at count=2 -> abort pulses once, done stays 0, next grant starts search at requester 3.
REQ-030 Reset mid-run: assert rst at count=4 -> all outputs are 0 within the same cycle; after release with req=1010 -> gnt=0010.
REQ-031 len change: len changes from 2 to 6 during RUN -> the slot still ends after 3 cycles.

Source files
------------

// File: rtl/counter_sched.sv
// counter_sched: round-robin arbiter that grants a shared up-counter slot of len+1 cycles to one requester at a time.
module counter_sched #(
    parameter int N_REQ = 4,
    parameter int CW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [CW-1:0]    len,
    output logic [N_REQ-1:0] gnt,
    output logic [CW-1:0]    count,
    output logic [N_REQ-1:0] done,
    output logic             abort,
    output logic             busy
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d, done_q, done_d;
    logic [CW-1:0]    count_q, count_d, term_q, term_d;
    logic [PW-1:0]    win_q, win_d, rr_q, rr_d, pick, win_nx;
    logic             abort_q, abort_d, busy_q;
    // Scan downward in offset so the lowest offset from rr_q is the last writer.
    always_comb begin
        pick = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (req[(int'(rr_q) + i) % N_REQ]) pick = PW'((int'(rr_q) + i) % N_REQ);
    end
    assign win_nx = (int'(win_q) == N_REQ - 1) ? '0 : win_q + PW'(1);
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        count_d = count_q;
        term_d  = term_q;
        win_d   = win_q;
        rr_d    = rr_q;
        done_d  = '0;
        abort_d = 1'b0;
        case (state_q)
            IDLE: if (|req) begin
                state_d = RUN;
                win_d   = pick;
                gnt_d   = N_REQ'(1) << pick;
                count_d = '0;
                term_d  = len;
            end
            RUN: if (!req[win_q]) begin
                state_d = IDLE;
                gnt_d   = '0;
                count_d = '0;
                abort_d = 1'b1;
                rr_d    = win_nx;
            end else if (count_q == term_q) begin
                state_d = DONE;
                gnt_d   = '0;
                done_d  = gnt_q;
                rr_d    = win_nx;
            end else begin
                count_d = count_q + CW'(1);
            end
            DONE: begin
                state_d = IDLE;
                count_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            count_q <= '0;
            term_q  <= '0;
            win_q   <= '0;
            rr_q    <= '0;
            done_q  <= '0;
            abort_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            count_q <= count_d;
            term_q  <= term_d;
            win_q   <= win_d;
            rr_q    <= rr_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            busy_q  <= (state_d != IDLE);
        end
    end
    assign gnt   = gnt_q;
    assign count = count_q;
    assign done  = done_q;
    assign abort = abort_q;
    assign busy  = busy_q;
endmodule

// File: tb/tb_counter_sched.sv
// tb_counter_sched: directed and random stimulus against a slot-level reference model of counter_sched.
module tb_counter_sched;
    localparam int N = 4;
    localparam int W = 3;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [W-1:0] len = '0;
    logic [N-1:0] gnt, done;
    logic [W-1:0] count;
    logic         abort, busy;
    int n_chk = 0;
    int n_fail = 0;
    // Reference: phase 0 idle, 1 in a slot, 2 the completion cycle.
    int ph, owner, cnt, term, rr, e_done, e_abort;

    counter_sched #(.N_REQ(N), .CW(W)) dut (
        .clk(clk), .rst(rst), .req(req), .len(len),
        .gnt(gnt), .count(count), .done(done), .abort(abort), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("gnt",   32'(gnt),   (ph == 1) ? (32'd1 << owner) : 32'd0);
        check("count", 32'(count), 32'(cnt));
        check("done",  32'(done),  32'(e_done));
        check("abort", 32'(abort), 32'(e_abort));
        check("busy",  32'(busy),  32'(ph != 0));
        check("gnt_done_excl", 32'((|gnt) && (|done)), 32'd0);
        check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    endtask

    task automatic model_step();
        e_done  = 0;
        e_abort = 0;
        if (ph == 0) begin
            if (req != 0) begin
                for (int k = N - 1; k >= 0; k--)
                    if (req[(rr + k) % N]) owner = (rr + k) % N;
                ph = 1;
                cnt = 0;
                term = int'(len);
            end
        end else if (ph == 1) begin
            if (!req[owner]) begin
                ph = 0; cnt = 0; e_abort = 1; rr = (owner + 1) % N;
            end else if (cnt == term) begin
                ph = 2; e_done = 1 << owner; rr = (owner + 1) % N;
            end else begin
                cnt++;
            end
        end else begin
            ph = 0;
            cnt = 0;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        ph = 0; owner = 0; cnt = 0; term = 0; rr = 0; e_done = 0; e_abort = 0;
        compare_all();
        #2;
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        // single request, len=3
        req = 4'b0001; len = 3'd3;
        for (int c = 0; c < 4; c++) begin
            cycle();
            check("single_cnt", 32'(count), 32'(c));
        end
        cycle();
        check("single_done", 32'(done), 32'h1);
        req = '0;
        cycle();
        check("single_idle", 32'(busy), 32'h0);
        // round robin with all requesting, len=0
        do_reset();
        req = 4'b1111; len = 3'd0;
        repeat (15) cycle();
        req = '0;
        cycle();
        // full length, no wrap
        req = 4'b0001; len = 3'd7;
        repeat (8) cycle();
        check("full_last", 32'(count), 32'd7);
        cycle();
        check("full_done", 32'(done), 32'h1);
        req = '0;
        repeat (2) cycle();
        // abort mid-slot
        req = 4'b0100; len = 3'd5;
        repeat (3) cycle();
        check("abort_at2", 32'(count), 32'd2);
        req = '0;
        cycle();
        check("abort_pulse", 32'(abort), 32'h1);
        req = 4'b1111;
        cycle();
        check("after_abort", 32'(gnt), 32'h8);
        req = '0;
        repeat (3) cycle();
        // len change during slot
        req = 4'b0001; len = 3'd2;
        cycle();
        len = 3'd6;
        repeat (3) cycle();
        check("len_ignored", 32'(done), 32'h1);
        req = '0;
        repeat (2) cycle();
        // async reset mid-slot
        req = 4'b0001; len = 3'd7;
        repeat (5) cycle();
        check("pre_rst_cnt", 32'(count), 32'd4);
        #2;
        do_reset();
        check("rst_gnt", 32'(gnt), 32'h0);
        req = 4'b1010;
        cycle();
        check("rst_restart", 32'(gnt), 32'h2);
        // random traffic
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(3) == 0) req = N'($urandom);
            len = W'($urandom);
            if ($urandom_range(149) == 0) do_reset();
            else cycle();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
